// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
//   Shared definitions for the Pong keyboard decoder: PS/2 set-2 scan codes
//   used by the game and the prefix-tracking FSM state type.
// -----------------------------------------------------------------------------
package kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Normal (unprefixed) keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Extended (E0-prefixed) keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE,     // waiting for a fresh code
    BRK,      // F0 seen
    EXT,      // E0 seen
    EXT_BRK   // E0 F0 seen
  } kbd_state_t;

endpackage

// File: rtl/kbd_prefix_timer.sv
// -----------------------------------------------------------------------------
// kbd_prefix_timer
//   Counts idle cycles while a scan-code prefix is pending. Synchronous clear
//   has priority over enable; expired is high while the count sits at
//   TIMEOUT-1.
//
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clear    in   zero the counter
//   enable   in   advance the counter by one
//   expired  out  count == TIMEOUT-1
// -----------------------------------------------------------------------------
module kbd_prefix_timer #(
  parameter int TIMEOUT = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pong_keyboard_decoder.sv
// -----------------------------------------------------------------------------
// pong_keyboard_decoder
//   Turns PS/2 scan-code bytes into level-held movement requests for both
//   players and a one-cycle serve pulse on the Space press edge. Tracks the
//   F0 (break) and E0 (extended) prefixes; a prefix left pending for
//   PREFIX_TIMEOUT idle cycles is abandoned.
//
//   Optional build macro KBD_ESC_RELEASE_EN: a make of Esc (0x76) releases
//   all four movement keys and the Space latch, and suppresses serve.
//
//   clk         in   system clock (pixel clock domain)
//   rst         in   synchronous active-high reset
//   rx_data     in   [7:0] scan-code byte from the PS/2 receiver
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   left_up     out  W held
//   left_down   out  S held
//   right_up    out  Up arrow (E0 75) held
//   right_down  out  Down arrow (E0 72) held
//   serve       out  one-cycle pulse on Space press
// -----------------------------------------------------------------------------
module pong_keyboard_decoder
  import kbd_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       left_up,
  output logic       left_down,
  output logic       right_up,
  output logic       right_down,
  output logic       serve
);

  kbd_state_t state, state_nxt;

  logic left_up_nxt, left_down_nxt, right_up_nxt, right_down_nxt;
  logic serve_nxt;
  logic space_held, space_held_nxt;

  logic timer_clear, timer_enable, timer_expired;

  // The counter only runs while a prefix waits for its next byte.
  assign timer_clear  = rx_valid || (state == IDLE);
  assign timer_enable = (state != IDLE) && !rx_valid;

  kbd_prefix_timer #(
    .TIMEOUT (PREFIX_TIMEOUT)
  ) u_prefix_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    left_up_nxt    = left_up;
    left_down_nxt  = left_down;
    right_up_nxt   = right_up;
    right_down_nxt = right_down;
    space_held_nxt = space_held;
    serve_nxt      = 1'b0;

    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_data == SC_BREAK) begin
            state_nxt = BRK;
          end else if (rx_data == SC_EXT) begin
            state_nxt = EXT;
          end else begin
            // Make of a normal code; repeats of a held key re-set the same value.
            case (rx_data)
              SC_W: left_up_nxt   = 1'b1;
              SC_S: left_down_nxt = 1'b1;
              SC_SPACE: begin
                if (!space_held) serve_nxt = 1'b1;
                space_held_nxt = 1'b1;
              end
`ifdef KBD_ESC_RELEASE_EN
              SC_ESC: begin
                left_up_nxt    = 1'b0;
                left_down_nxt  = 1'b0;
                right_up_nxt   = 1'b0;
                right_down_nxt = 1'b0;
                space_held_nxt = 1'b0;
                serve_nxt      = 1'b0;
              end
`endif
              default: ;
            endcase
          end
        end

        BRK: begin
          // A prefix byte here is malformed and treated as an unknown code.
          case (rx_data)
            SC_W:     left_up_nxt    = 1'b0;
            SC_S:     left_down_nxt  = 1'b0;
            SC_SPACE: space_held_nxt = 1'b0;
            default:  ;
          endcase
          state_nxt = IDLE;
        end

        EXT: begin
          if (rx_data == SC_BREAK) begin
            state_nxt = EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            state_nxt = EXT;
          end else begin
            case (rx_data)
              SC_UP:   right_up_nxt   = 1'b1;
              SC_DOWN: right_down_nxt = 1'b1;
              default: ;
            endcase
            state_nxt = IDLE;
          end
        end

        EXT_BRK: begin
          case (rx_data)
            SC_UP:   right_up_nxt   = 1'b0;
            SC_DOWN: right_down_nxt = 1'b0;
            default: ;
          endcase
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end else if ((state != IDLE) && timer_expired) begin
      // Stale prefix: drop it without touching the outputs.
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      left_up    <= 1'b0;
      left_down  <= 1'b0;
      right_up   <= 1'b0;
      right_down <= 1'b0;
      space_held <= 1'b0;
      serve      <= 1'b0;
    end else begin
      state      <= state_nxt;
      left_up    <= left_up_nxt;
      left_down  <= left_down_nxt;
      right_up   <= right_up_nxt;
      right_down <= right_down_nxt;
      space_held <= space_held_nxt;
      serve      <= serve_nxt;
    end
  end

endmodule
